// File: rtl/map_ctrl_pkg.sv
// Shared types and default constants for the MAP decoder window controllers.
package map_ctrl_pkg;

  localparam int unsigned NUM_TRELLIS_STATES = 8;
  localparam int unsigned BETA_ADDR_W        = 8;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    CALC,
    WRITE,
    CHECK,
    DONE,
    WAIT_LLR,
    READ,
    STOP
  } bck_state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bck_lat_cnt.sv
// Loadable down-counter that times the beta datapath pipeline window.
module bck_lat_cnt #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/cont_bck_win.sv
// Backward (beta) recursion controller: writes one beta vector per trellis
// step in descending address order, then streams them out ascending.
module cont_bck_win
  import map_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = BETA_ADDR_W,
  parameter int unsigned STRIDE    = NUM_TRELLIS_STATES,
  parameter int unsigned WIN_LEN   = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned PIPE_LAT  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         flush,
  input  logic                         llr_go,
  output logic                         w_r_b,
  output logic [ADDR_W-1:0]            bd_addr,
  output logic                         calc_en,
  output logic [$clog2(WIN_LEN+1)-1:0] step_idx,
  output logic                         rd_valid,
  output logic                         busy,
  output logic                         done_bck,
  output logic                         stop
);

  localparam int unsigned STEP_W = $clog2(WIN_LEN + 1);
  localparam int unsigned LAT_W  = cnt_width(PIPE_LAT);

  localparam logic [ADDR_W-1:0] BASE_C   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STRIDE_C = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] LOAD_C   = ADDR_W'(BASE_ADDR + WIN_LEN * STRIDE);
  localparam logic [STEP_W-1:0] WIN_C    = STEP_W'(WIN_LEN);
  localparam logic [STEP_W-1:0] LAST_C   = STEP_W'(WIN_LEN - 1);
  localparam logic [LAT_W-1:0]  LAT_C    = LAT_W'(PIPE_LAT - 1);

  localparam bit CFG_OK =
    (longint'(BASE_ADDR) + longint'(WIN_LEN) * longint'(STRIDE)) < (longint'(1) << ADDR_W);

  bck_state_t          state_q, state_d;
  logic                w_r_b_q, w_r_b_d;
  logic [ADDR_W-1:0]   bd_addr_q, bd_addr_d;
  logic                calc_en_q, calc_en_d;
  logic [STEP_W-1:0]   step_idx_q, step_idx_d;
  logic                rd_valid_q, rd_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                stop_q, stop_d;
  logic                lat_load;
  logic                lat_zero;

  bck_lat_cnt #(
    .CNT_W(LAT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (lat_load),
    .load_val (LAT_C),
    .zero     (lat_zero)
  );

  // Output flops are computed from the next state, so each output is
  // valid during the cycle its state is occupied.
  always_comb begin
    state_d    = state_q;
    w_r_b_d    = 1'b0;
    bd_addr_d  = bd_addr_q;
    calc_en_d  = 1'b0;
    step_idx_d = step_idx_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    stop_d     = stop_q;
    lat_load   = 1'b0;

    case (state_q)
      IDLE, STOP: begin
        if (start) begin
          state_d    = LOAD;
          bd_addr_d  = LOAD_C;
          step_idx_d = WIN_C;
          stop_d     = 1'b0;
        end
      end
      LOAD: begin
        state_d   = CALC;
        calc_en_d = 1'b1;
        lat_load  = 1'b1;
      end
      CALC: begin
        if (lat_zero) begin
          state_d    = WRITE;
          w_r_b_d    = 1'b1;
          bd_addr_d  = bd_addr_q - STRIDE_C;
          step_idx_d = step_idx_q - STEP_W'(1);
        end else begin
          calc_en_d = 1'b1;
        end
      end
      WRITE: state_d = CHECK;
      CHECK: begin
        if (step_idx_q != '0) begin
          state_d   = CALC;
          calc_en_d = 1'b1;
          lat_load  = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: state_d = WAIT_LLR;
      WAIT_LLR: begin
        if (llr_go) begin
          state_d    = READ;
          bd_addr_d  = BASE_C;
          step_idx_d = '0;
          rd_valid_d = 1'b1;
        end
      end
      READ: begin
        if (step_idx_q == LAST_C) begin
          state_d = STOP;
          stop_d  = 1'b1;
        end else begin
          rd_valid_d = 1'b1;
          bd_addr_d  = bd_addr_q + STRIDE_C;
          step_idx_d = step_idx_q + STEP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d    = IDLE;
      w_r_b_d    = 1'b0;
      bd_addr_d  = '0;
      calc_en_d  = 1'b0;
      step_idx_d = '0;
      rd_valid_d = 1'b0;
      done_d     = 1'b0;
      stop_d     = 1'b0;
      lat_load   = 1'b0;
    end

    busy_d = (state_d != IDLE) && (state_d != STOP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      w_r_b_q    <= 1'b0;
      bd_addr_q  <= '0;
      calc_en_q  <= 1'b0;
      step_idx_q <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      assert (CFG_OK)
        else $error("cont_bck_win: BASE_ADDR+WIN_LEN*STRIDE overflows ADDR_W");
      state_q    <= state_d;
      w_r_b_q    <= w_r_b_d;
      bd_addr_q  <= bd_addr_d;
      calc_en_q  <= calc_en_d;
      step_idx_q <= step_idx_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      stop_q     <= stop_d;
    end
  end

  assign w_r_b    = w_r_b_q;
  assign bd_addr  = bd_addr_q;
  assign calc_en  = calc_en_q;
  assign step_idx = step_idx_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign done_bck = done_q;
  assign stop     = stop_q;

endmodule

// File: tb/tb_cont_bck_win.sv
// Directed self-checking bench for cont_bck_win (default and two alternate configurations).
module tb_cont_bck_win;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  // default instance
  logic       start = 1'b0, llr_go = 1'b0;
  logic       w_r_b, calc_en, rd_valid, busy, done_bck, stop;
  logic [7:0] bd_addr;
  logic [3:0] step_idx;

  cont_bck_win #(
    .ADDR_W(8), .STRIDE(8), .WIN_LEN(8), .BASE_ADDR(0), .PIPE_LAT(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .llr_go(llr_go),
    .w_r_b(w_r_b), .bd_addr(bd_addr), .calc_en(calc_en), .step_idx(step_idx),
    .rd_valid(rd_valid), .busy(busy), .done_bck(done_bck), .stop(stop)
  );

  // PIPE_LAT=4, WIN_LEN=3, BASE_ADDR=16
  logic       start2 = 1'b0, llr2 = 1'b0;
  logic       w_r_b2, calc_en2, rd_valid2, busy2, done2, stop2;
  logic [7:0] bd_addr2;
  logic [1:0] step_idx2;

  cont_bck_win #(
    .ADDR_W(8), .STRIDE(8), .WIN_LEN(3), .BASE_ADDR(16), .PIPE_LAT(4)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .flush(1'b0), .llr_go(llr2),
    .w_r_b(w_r_b2), .bd_addr(bd_addr2), .calc_en(calc_en2), .step_idx(step_idx2),
    .rd_valid(rd_valid2), .busy(busy2), .done_bck(done2), .stop(stop2)
  );

  // WIN_LEN=1, PIPE_LAT=1
  logic       start3 = 1'b0, llr3 = 1'b0;
  logic       w_r_b3, calc_en3, rd_valid3, busy3, done3, stop3;
  logic [7:0] bd_addr3;
  logic [0:0] step_idx3;

  cont_bck_win #(
    .ADDR_W(8), .STRIDE(8), .WIN_LEN(1), .BASE_ADDR(0), .PIPE_LAT(1)
  ) dut3 (
    .clk(clk), .rst(rst), .start(start3), .flush(1'b0), .llr_go(llr3),
    .w_r_b(w_r_b3), .bd_addr(bd_addr3), .calc_en(calc_en3), .step_idx(step_idx3),
    .rd_valid(rd_valid3), .busy(busy3), .done_bck(done3), .stop(stop3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {14'd0, w_r_b, bd_addr, calc_en, step_idx, rd_valid, busy, done_bck, stop}, 32'd0);
  endtask

  task automatic run_window(input int inject_k, input int flush_k);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_addr", bd_addr, 64);
    chk("load_step", step_idx, 8);
    chk("load_wrb", w_r_b, 0);
    chk("load_stop", stop, 0);
    chk("load_busy", busy, 1);
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 2; c++) begin
        tick();
        chk("calc_en", calc_en, 1);
        chk("calc_wrb", w_r_b, 0);
        start  = (k == inject_k) && (c == 0);
        llr_go = (k == inject_k) && (c == 0);
      end
      tick();
      chk("wr_strobe", w_r_b, 1);
      chk("wr_addr", bd_addr, 56 - 8 * k);
      chk("wr_step", step_idx, 7 - k);
      chk("wr_calc", calc_en, 0);
      if (k == flush_k) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_zero("flush_zero");
        return;
      end
      tick();
      chk("chk_wrb", w_r_b, 0);
      chk("chk_done", done_bck, 0);
    end
    tick();
    chk("done_pulse", done_bck, 1);
    llr_go = 1'b1;
    tick();
    llr_go = 1'b0;
    chk("done_clear", done_bck, 0);
    chk("llr_in_done", rd_valid, 0);
    chk("wait_busy", busy, 1);
  endtask

  task automatic readout(input int rst_at);
    repeat (9) tick();
    chk("wait_hold", {rd_valid, busy, done_bck}, 3'b010);
    llr_go = 1'b1;
    tick();
    llr_go = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == rst_at) begin
        #2 rst = 1'b0;
        #1 chk_zero("rst_async");
        tick();
        chk_zero("rst_hold");
        rst = 1'b1;
        return;
      end
      chk("rd_valid", rd_valid, 1);
      chk("rd_addr", bd_addr, 8 * i);
      chk("rd_step", step_idx, i);
      chk("rd_wrb", w_r_b, 0);
      tick();
    end
    chk("stop_rdv", rd_valid, 0);
    chk("stop_set", stop, 1);
    chk("stop_busy", busy, 0);
    tick();
    chk("stop_sticky", stop, 1);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b1;
    tick();
    chk_zero("idle");

    run_window(-1, -1);
    readout(-1);
    run_window(-1, -1);
    readout(3);
    tick();
    chk_zero("post_rst_idle");

    run_window(2, -1);
    readout(-1);
    run_window(-1, 2);
    tick();
    chk_zero("flush_idle");
    run_window(-1, -1);
    readout(-1);

    // alternate configuration: BASE 16, 3 steps, 4-cycle pipeline
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("c2_load_addr", bd_addr2, 40);
    chk("c2_load_step", step_idx2, 3);
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        chk("c2_calc_en", calc_en2, 1);
      end
      tick();
      chk("c2_wr", {w_r_b2, calc_en2}, 2'b10);
      chk("c2_wr_addr", bd_addr2, 32 - 8 * k);
      tick();
      chk("c2_chk_wrb", w_r_b2, 0);
    end
    tick();
    chk("c2_done", done2, 1);
    tick();
    llr2 = 1'b1;
    tick();
    llr2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("c2_rd", {rd_valid2, bd_addr2}, {1'b1, 8'(16 + 8 * i)});
      tick();
    end
    chk("c2_stop", {rd_valid2, stop2, busy2}, 3'b010);

    // single-step window
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    chk("c3_load", {bd_addr3, step_idx3}, {8'd8, 1'b1});
    tick();
    chk("c3_calc", calc_en3, 1);
    tick();
    chk("c3_wr", {w_r_b3, bd_addr3, step_idx3}, {1'b1, 8'd0, 1'b0});
    tick();
    chk("c3_check", w_r_b3, 0);
    tick();
    chk("c3_done", done3, 1);
    tick();
    llr3 = 1'b1;
    tick();
    llr3 = 1'b0;
    chk("c3_rd", {rd_valid3, bd_addr3}, {1'b1, 8'd0});
    tick();
    chk("c3_stop", {rd_valid3, stop3, busy3}, 3'b010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cont_bck_win.md
Name: cont_bck_win

Overview:
- Parametrised backward-recursion controller for the MAP decoder.
- Sequences the beta recursion over one trellis window: reads the initial beta, drives the beta datapath for a configurable pipeline latency, and writes one beta vector per trellis step into the beta/alpha SRAM in descending address order.
- After the recursion it waits for an explicit LLR handshake and streams the stored betas out in ascending order.
- Replaces fixed window length, fixed latency, external step counting and magic main-counter compares with parameters and handshakes.

Parameters:
- ADDR_W, 8, SRAM address width.
- STRIDE, 8, address increment per trellis step (one beta vector = NUM_STATES words).
- WIN_LEN, 8, trellis steps per window, >=1.
- BASE_ADDR, 0, address of step 0 beta vector.
- PIPE_LAT, 2, beta datapath cycles (add + compare) per step, >=1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a window recursion when idle or stopped.
- flush  in  1  synchronous abort; returns to IDLE next cycle.
- llr_go  in  1  pulse from main controller; begins beta readout.
- w_r_b  out  1  SRAM write strobe (1 = write, 0 = read).
- bd_addr  out  ADDR_W  SRAM address.
- calc_en  out  1  high while the beta datapath is computing.
- step_idx  out  $clog2(WIN_LEN+1)  current trellis step.
- rd_valid  out  1  high on each readout address cycle.
- busy  out  1  high in any state other than IDLE/STOP.
- done_bck  out  1  one-cycle pulse when recursion completes.
- stop  out  1  sticky; high after readout completes.

Behaviour:
- Reset (rst=0, async): state=IDLE, w_r_b=0, bd_addr=0, calc_en=0, step_idx=0, rd_valid=0, busy=0, done_bck=0, stop=0. Outputs are registered.
- IDLE: on start, go to LOAD.
- LOAD (1 cycle): bd_addr=BASE_ADDR+WIN_LEN*STRIDE, w_r_b=0 (initial beta read), step_idx=WIN_LEN. Go to CALC.
- CALC: calc_en=1 for exactly PIPE_LAT cycles (internal latency counter), then go to WRITE.
- WRITE (1 cycle):
  - bd_addr -= STRIDE, step_idx -= 1, w_r_b=1.
  - Go to CHECK.
- CHECK (1 cycle): w_r_b=0. If step_idx != 0, go to CALC; else go to DONE.
- Each step costs PIPE_LAT+2 cycles. Write addresses run BASE+(WIN_LEN-1)*STRIDE down to BASE.
- DONE (1 cycle): done_bck=1, then go to WAIT_LLR.
- WAIT_LLR: done_bck=0, busy=1. Hold until llr_go, then bd_addr=BASE_ADDR, step_idx=0, go to READ.
- READ:
  - rd_valid=1, w_r_b=0.
  - Each cycle: bd_addr += STRIDE, step_idx += 1.
  - After WIN_LEN valid cycles (addresses BASE .. BASE+(WIN_LEN-1)*STRIDE), go to STOP with rd_valid=0.
- STOP: stop=1 held. start clears stop and goes to LOAD (back-to-back windows).
- Boundary and priority rules:
  - start while busy: ignored.
  - llr_go outside WAIT_LLR: ignored. llr_go arriving in the same cycle as done_bck: ignored; it must arrive in WAIT_LLR.
  - flush has priority over start/llr_go in every state. flush: next cycle IDLE, all outputs at reset values, stop cleared.
  - WIN_LEN=1: exactly one write at BASE, one read at BASE.
  - Address arithmetic is unsigned modulo 2^ADDR_W. The configuration must satisfy BASE_ADDR+WIN_LEN*STRIDE < 2^ADDR_W; a simulation-time assertion checks this, and no wrap ever occurs in a legal configuration.
  - rst asserted mid-operation: immediate return to reset values; no partial write completes after reset assertion.

Decomposition:
- Shared package map_ctrl_pkg holds:
  - state encoding enum bck_state_t (IDLE, LOAD, CALC, WRITE, CHECK, DONE, WAIT_LLR, READ, STOP);
  - default constants NUM_TRELLIS_STATES=8 and BETA_ADDR_W=8, also used by the forward controller.
- One natural sub-module: bck_lat_cnt, a loadable down-counter generating the PIPE_LAT-cycle calc window. Everything else stays in the top FSM.

Test Plan:
- Defaults, start pulse:
  - LOAD reads addr 64.
  - Writes (w_r_b=1) at 56,48,40,32,24,16,8,0, spaced 4 cycles apart.
  - done_bck pulses once, 1 cycle after the last CHECK.
- After done_bck, wait 10 cycles, then llr_go: rd_valid high 8 consecutive cycles with addr 0,8,...,56; then stop=1 and busy=0.
- PIPE_LAT=4, WIN_LEN=3, BASE_ADDR=16: reads 40; writes 32,24,16, spaced 6 cycles apart (calc_en high 4 cycles each); readout 16,24,32.
- start and llr_go pulsed during CALC: no effect; write sequence unchanged.
- flush asserted in the cycle of the 3rd write: next cycle IDLE, all outputs zero; a following start restarts cleanly from addr 64.
- rst driven low asynchronously mid-READ: outputs zero immediately (before next clk edge). In STOP, a start clears stop and repeats the full default sequence.
